// File: rtl/mem_io_ctrl_pkg.sv
// Shared address map and read-source encoding for the memory/IO controller.
package mem_io_ctrl_pkg;

    localparam logic [17:0] IO_DATA_ADDR = 18'h30000;
    localparam logic [17:0] IO_CNT_ADDR  = 18'h30004;
    localparam logic [1:0]  IO_TAG       = 2'b11;
    localparam logic [1:0]  HOLE_TAG     = 2'b10;
    localparam int unsigned RAM_AW       = 17;
    localparam int unsigned RAM_BYTES    = 131072;

    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_IO   = 2'd2
    } rd_src_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO; a pop frees the slot a same-cycle push may fill.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   push_i,
    input  logic [7:0]             push_data_i,
    input  logic                   pop_i,
    output logic [7:0]             head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign count_o = cnt_q;
    assign head_o  = empty_o ? 8'h00 : mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            if (do_push && !do_pop)
                cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push)
                cnt_q <= cnt_q - 1'b1;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end

endmodule

// File: rtl/mem_io_ctrl.sv
// CPU-facing byte RAM plus memory-mapped UART FIFOs, cycle counter and stop flag.
module mem_io_ctrl
    import mem_io_ctrl_pkg::*;
#(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        program_done
);
    localparam int TXCW = $clog2(TX_DEPTH) + 1;
    localparam int RXCW = $clog2(RX_DEPTH) + 1;

    logic [17:0]       addr;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_sel;
    logic              io_sel;
    logic              addr_hi_unused;

    assign addr           = mem_a[17:0];
    assign ram_idx        = mem_a[RAM_AW-1:0];
    assign io_sel         = (addr[17:16] == IO_TAG);
    assign ram_sel        = !io_sel && (addr[17:16] != HOLE_TAG);
    assign addr_hi_unused = ^mem_a[31:18];

    logic [7:0] ram_q [RAM_BYTES];
    logic [7:0] ram_rd_q;

    always_ff @(posedge clk_in) begin
        if (ram_sel && mem_wr) ram_q[ram_idx] <= mem_dout;
        ram_rd_q <= ram_q[ram_idx];
    end

    logic [7:0]      rx_head;
    logic [7:0]      tx_head;
    logic            rx_pop;
    logic            tx_push;
    logic            tx_pop;
    logic [7:0]      tx_push_data;
    logic [TXCW-1:0] tx_count;
    logic            tx_empty;
    logic [RXCW-1:0] rx_count_unused;
    logic            rx_full_unused;
    logic            rx_empty_unused;
    logic            tx_full_unused;

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .push_i      (rx_valid),
        .push_data_i (rx_data),
        .pop_i       (rx_pop),
        .head_o      (rx_head),
        .count_o     (rx_count_unused),
        .full_o      (rx_full_unused),
        .empty_o     (rx_empty_unused)
    );

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .push_i      (tx_push),
        .push_data_i (tx_push_data),
        .pop_i       (tx_pop),
        .head_o      (tx_head),
        .count_o     (tx_count),
        .full_o      (tx_full_unused),
        .empty_o     (tx_empty)
    );

    assign tx_valid       = !tx_empty;
    assign tx_data        = tx_head;
    assign tx_pop         = tx_valid && tx_ready;
    // Threshold leaves room for one write already issued when the CPU sees it.
    assign io_buffer_full = (tx_count >= TXCW'(TX_DEPTH - 2));

    rd_src_e     src_q, src_d;
    logic [7:0]  io_rd_q, io_rd_d;
    logic [31:0] cnt_q;
    logic [31:0] snap_q, snap_d;
    logic        done_q, done_d;

    always_comb begin
        src_d        = SRC_ZERO;
        io_rd_d      = 8'h00;
        snap_d       = snap_q;
        done_d       = done_q;
        rx_pop       = 1'b0;
        tx_push      = 1'b0;
        tx_push_data = mem_dout;
        if (!mem_wr) begin
            if (ram_sel) src_d = SRC_RAM;
            else if (io_sel) src_d = SRC_IO;
        end
        if (io_sel && !mem_wr) begin
            case (addr)
                IO_DATA_ADDR: begin
                    rx_pop  = 1'b1;
                    io_rd_d = rx_head;
                end
                IO_CNT_ADDR: begin
                    snap_d  = cnt_q;
                    io_rd_d = cnt_q[7:0];
                end
                IO_CNT_ADDR + 18'd1: io_rd_d = snap_q[15:8];
                IO_CNT_ADDR + 18'd2: io_rd_d = snap_q[23:16];
                IO_CNT_ADDR + 18'd3: io_rd_d = snap_q[31:24];
                default: io_rd_d = 8'h00;
            endcase
        end
        if (io_sel && mem_wr) begin
            if (addr == IO_DATA_ADDR && mem_dout != 8'h00) begin
                tx_push = 1'b1;
            end else if (addr == IO_CNT_ADDR) begin
                tx_push      = 1'b1;
                tx_push_data = 8'h00;
                done_d       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            src_q   <= SRC_ZERO;
            io_rd_q <= 8'h00;
            cnt_q   <= 32'h0;
            snap_q  <= 32'h0;
            done_q  <= 1'b0;
        end else begin
            src_q   <= src_d;
            io_rd_q <= io_rd_d;
            cnt_q   <= cnt_q + 32'h1;
            snap_q  <= snap_d;
            done_q  <= done_d;
        end
    end

    assign mem_din      = (src_q == SRC_RAM) ? ram_rd_q : io_rd_q;
    assign program_done = done_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed and randomized bench for mem_io_ctrl against a queue-based reference model.
module tb_mem_io_ctrl;
    localparam int TXD = 16;
    localparam int RXD = 4;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [31:0] mem_a = 32'h0002_0000;
    logic [7:0]  mem_dout = 8'h00;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        program_done;

    always #5 clk_in = ~clk_in;

    mem_io_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .program_done   (program_done)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  ram_m [int];
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic [7:0]  obs_tx[$];
    logic [31:0] cnt_m = 32'h0;
    logic [31:0] snap_m = 32'h0;
    logic        pd_m = 1'b0;
    logic [7:0]  last_din;
    logic [16:0] pool [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("tx_valid", 32'(tx_valid), 32'(txq.size() != 0));
        check("tx_data", 32'(tx_data), 32'((txq.size() != 0) ? txq[0] : 8'h00));
        check("io_buffer_full", 32'(io_buffer_full), 32'(txq.size() >= TXD - 2));
        check("program_done", 32'(program_done), 32'(pd_m));
    endtask

    // One bus cycle: check outputs, drive inputs, advance the model, then check read data.
    task automatic step(input logic [31:0] a, input logic [7:0] d, input logic wr,
                        input logic rxv, input logic [7:0] rxd, input logic txr);
        logic [17:0] ad;
        logic [7:0]  exp_rd;
        logic        push_tx;
        logic [7:0]  push_val;
        check_outputs();
        if (tx_valid && txr) obs_tx.push_back(tx_data);
        mem_a = a; mem_dout = d; mem_wr = wr;
        rx_valid = rxv; rx_data = rxd; tx_ready = txr;
        ad = a[17:0];
        exp_rd = 8'h00;
        push_tx = 1'b0;
        push_val = d;
        if (txq.size() != 0 && txr) txq.delete(0);
        if (!wr) begin
            if (ad[17:16] == 2'b11) begin
                if (ad == 18'h30000) begin
                    if (rxq.size() != 0) begin
                        exp_rd = rxq[0];
                        rxq.delete(0);
                    end
                end else if (ad == 18'h30004) begin
                    snap_m = cnt_m;
                    exp_rd = cnt_m[7:0];
                end else if (ad == 18'h30005) exp_rd = snap_m[15:8];
                else if (ad == 18'h30006) exp_rd = snap_m[23:16];
                else if (ad == 18'h30007) exp_rd = snap_m[31:24];
            end else if (ad[17] == 1'b0) begin
                exp_rd = ram_m[int'(ad[16:0])];
            end
        end else begin
            if (ad[17] == 1'b0) ram_m[int'(ad[16:0])] = d;
            else if (ad == 18'h30000 && d != 8'h00) push_tx = 1'b1;
            else if (ad == 18'h30004) begin
                push_tx = 1'b1;
                push_val = 8'h00;
                pd_m = 1'b1;
            end
        end
        if (push_tx && txq.size() < TXD) txq.push_back(push_val);
        if (rxv && rxq.size() < RXD) rxq.push_back(rxd);
        cnt_m = cnt_m + 32'h1;
        @(posedge clk_in);
        #1;
        last_din = mem_din;
        if (!wr) check("rd_data", 32'(mem_din), 32'(exp_rd));
    endtask

    task automatic idle(input logic txr);
        step(32'h0002_0000, 8'h00, 1'b0, 1'b0, 8'h00, txr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [31:0] asm;
        logic [31:0] a;
        logic [31:0] hi;
        logic [7:0]  d;
        logic        w;
        int unsigned ch;

        // Reset state
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_mem_din", 32'(mem_din), 32'h00);
        check_outputs();
        rst_n_in = 1'b1;

        // Counter snapshot 100 cycles after release
        repeat (100) idle(1'b0);
        asm = 32'h0;
        step(32'h0003_0004, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0); asm[7:0]   = last_din;
        step(32'h0003_0005, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0); asm[15:8]  = last_din;
        step(32'h0003_0006, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0); asm[23:16] = last_din;
        step(32'h0003_0007, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0); asm[31:24] = last_din;
        check("cnt_snapshot_100", asm, 32'd100);
        repeat (5) idle(1'b0);
        step(32'h0003_0005, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        check("cnt_no_resnap", 32'(last_din), 32'h00);

        // RAM write then read-back
        step(32'h0000_1234, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0);
        step(32'h0000_1234, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        check("ram_a5", 32'(last_din), 32'hA5);
        step(32'h0002_1234, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0);
        step(32'h0002_1234, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        step(32'h0000_1234, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        check("hole_write_ignored", 32'(last_din), 32'hA5);

        // TX: zero byte is not transmitted
        obs_tx.delete();
        step(32'h0003_0000, 8'h41, 1'b1, 1'b0, 8'h00, 1'b1);
        step(32'h0003_0000, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
        step(32'h0003_0000, 8'h42, 1'b1, 1'b0, 8'h00, 1'b1);
        repeat (3) idle(1'b1);
        check("tx_seq_len", 32'(obs_tx.size()), 32'd2);
        check("tx_seq_0", 32'((obs_tx.size() > 0) ? obs_tx[0] : 8'hFF), 32'h41);
        check("tx_seq_1", 32'((obs_tx.size() > 1) ? obs_tx[1] : 8'hFF), 32'h42);

        // TX back-pressure and overflow drop
        obs_tx.delete();
        for (int i = 1; i <= 13; i++) step(32'h0003_0000, 8'(i), 1'b1, 1'b0, 8'h00, 1'b0);
        check("ibf_at_13", 32'(io_buffer_full), 32'd0);
        step(32'h0003_0000, 8'd14, 1'b1, 1'b0, 8'h00, 1'b0);
        check("ibf_at_14", 32'(io_buffer_full), 32'd1);
        for (int i = 15; i <= 18; i++) step(32'h0003_0000, 8'(i), 1'b1, 1'b0, 8'h00, 1'b0);
        repeat (20) idle(1'b1);
        check("tx_drain_len", 32'(obs_tx.size()), 32'd16);
        for (int i = 0; i < obs_tx.size(); i++) check("tx_drain_data", 32'(obs_tx[i]), 32'(i + 1));

        // RX pop order and empty read
        step(32'h0002_0000, 8'h00, 1'b0, 1'b1, 8'h10, 1'b0);
        step(32'h0002_0000, 8'h00, 1'b0, 1'b1, 8'h20, 1'b0);
        step(32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        check("rx_first", 32'(last_din), 32'h10);
        step(32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        check("rx_second", 32'(last_din), 32'h20);
        step(32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        check("rx_empty", 32'(last_din), 32'h00);

        // RX full: overflow drop, then simultaneous push+pop
        for (int i = 1; i <= 5; i++) step(32'h0002_0000, 8'h00, 1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
        step(32'h0003_0000, 8'h00, 1'b0, 1'b1, 8'h55, 1'b0);
        check("rx_full_pop", 32'(last_din), 32'hA1);
        repeat (5) step(32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        check("rx_drained", 32'(last_din), 32'h00);

        // Randomized traffic
        for (int i = 0; i < 8; i++) begin
            pool[i] = 17'($urandom);
            step(32'(pool[i]), 8'($urandom), 1'b1, 1'b0, 8'h00, 1'b0);
        end
        for (int i = 0; i < 400; i++) begin
            ch = $urandom_range(0, 9);
            hi = $urandom & 32'hFFFC_0000;
            d  = 8'($urandom);
            w  = 1'b0;
            case (ch)
                0, 1, 2: begin a = hi | 32'(pool[$urandom_range(0, 7)]); w = 1'b1; end
                3, 4:    a = hi | 32'(pool[$urandom_range(0, 7)]);
                5: begin a = hi | 32'h0002_0000 | 32'($urandom_range(0, 16'hFFFF)); w = 1'($urandom); end
                6:       a = hi | 32'h0003_0000;
                7: begin
                    a = hi | 32'h0003_0000;
                    w = 1'b1;
                    if ($urandom_range(0, 3) == 0) d = 8'h00;
                end
                8:       a = hi | (32'h0003_0004 + 32'($urandom_range(0, 3)));
                default: begin a = hi | (32'h0003_0008 + 32'($urandom_range(0, 16'hFFF0))); w = 1'($urandom); end
            endcase
            step(a, d, w, 1'($urandom_range(0, 2) == 0), 8'($urandom), 1'($urandom));
        end

        // Stop flag, then asynchronous reset in the middle of a transfer
        repeat (TXD + 2) idle(1'b1);
        step(32'h0003_0004, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0);
        check("pd_set", 32'(program_done), 32'd1);
        check("pd_tx_zero_valid", 32'(tx_valid), 32'd1);
        check("pd_tx_zero_data", 32'(tx_data), 32'h00);
        mem_a = 32'h0003_0000; mem_dout = 8'h77; mem_wr = 1'b1;
        rx_valid = 1'b1; rx_data = 8'h99;
        #2;
        rst_n_in = 1'b0;
        #1;
        check("rst_pd", 32'(program_done), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_ibf", 32'(io_buffer_full), 32'd0);
        check("rst_mem_din", 32'(mem_din), 32'h00);
        repeat (2) @(posedge clk_in);
        #1;
        mem_a = 32'h0002_0000; mem_dout = 8'h00; mem_wr = 1'b0;
        rx_valid = 1'b0; tx_ready = 1'b0;
        rxq.delete(); txq.delete();
        cnt_m = 32'h0; snap_m = 32'h0; pd_m = 1'b0;
        rst_n_in = 1'b1;
        step(32'h0003_0005, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        step(32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        check("rx_empty_after_rst", 32'(last_din), 32'h00);
        step(32'(pool[0]), 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        step(32'h0000_1234, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        check("ram_kept_over_rst", 32'(last_din), 32'hA5);
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
